nv_nvdla_pdp_cal2d_pad_line_arb: RTL and testbench

//  Shares the fp16 mul-pad-line pipe stage of PDP cal2d between two requesters:

---
 rtl/nv_nvdla_pdp_cal2d_arb_pkg.sv | 18 +
 rtl/nv_nvdla_pdp_cal2d_pipe_stage.sv | 53 +++++
 rtl/nv_nvdla_pdp_cal2d_pad_line_arb.sv | 128 ++++++++++++
 tb/tb_nv_nvdla_pdp_cal2d_pad_line_arb.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nv_nvdla_pdp_cal2d_arb_pkg.sv
// Shared types and constants for the PDP cal2d pad-line arbiter.
package nv_nvdla_pdp_cal2d_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOCK_DAT = 2'd1,
        LOCK_PAD = 2'd2
    } arb_state_e;

    localparam logic SRC_DAT = 1'b0;
    localparam logic SRC_PAD = 1'b1;

    // On a tie the source that did not finish the previous burst wins.
    function automatic logic rr_pick(input logic rr_last);
        return ~rr_last;
    endfunction

endpackage

// File: rtl/nv_nvdla_pdp_cal2d_pipe_stage.sv
// Generic valid/ready register stage. The top RST_W bits of the payload are
// cleared by reset (sideband flags); the remaining payload bits are not reset.
module nv_nvdla_pdp_cal2d_pipe_stage #(
    parameter int W     = 117,
    parameter int RST_W = 2
) (
    input  logic         nvdla_op_gated_clk_fp16,
    input  logic         nvdla_core_rstn,
    input  logic         vld_in,
    output logic         rdy_in,
    input  logic [W-1:0] data_in,
    output logic         vld_out,
    input  logic         rdy_out,
    output logic [W-1:0] data_out
);

    logic                 vld_reg;
    logic [RST_W-1:0]     data_rs_reg;
    logic [W-RST_W-1:0]   data_nr_reg;
    logic                 load;

    // The stage can take a new beat when empty or when the current one leaves.
    assign rdy_in   = rdy_out | ~vld_out;
    assign load     = rdy_in & vld_in;
    assign vld_out  = vld_reg;
    assign data_out = {data_rs_reg, data_nr_reg};

    // Valid flag: refilled or emptied whenever the stage accepts.
    always_ff @(posedge nvdla_op_gated_clk_fp16 or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            vld_reg <= 1'b0;
        end else if (rdy_in) begin
            vld_reg <= vld_in;
        end
    end

    // Sideband bits with a defined reset value.
    always_ff @(posedge nvdla_op_gated_clk_fp16 or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            data_rs_reg <= '0;
        end else if (load) begin
            data_rs_reg <= data_in[W-1 -: RST_W];
        end
    end

    // Wide payload: no reset, held while stalled or idle.
    always_ff @(posedge nvdla_op_gated_clk_fp16) begin
        if (load) begin
            data_nr_reg <= data_in[W-RST_W-1:0];
        end
    end

endmodule

// File: rtl/nv_nvdla_pdp_cal2d_pad_line_arb.sv
// Round-robin, burst-locked arbiter between line data and synthesized pad
// lines in front of the fp16 mul-pad-line stage, with one output register.
module nv_nvdla_pdp_cal2d_pad_line_arb
    import nv_nvdla_pdp_cal2d_arb_pkg::*;
#(
    parameter int DW    = 115,
    parameter int CNT_W = 16
) (
    input  logic             nvdla_op_gated_clk_fp16,
    input  logic             nvdla_core_rstn,
    input  logic             arb_en,
    input  logic             dat_vld,
    output logic             dat_rdy,
    input  logic [DW-1:0]    dat_pd,
    input  logic             dat_last,
    input  logic             pad_vld,
    output logic             pad_rdy,
    input  logic [DW-1:0]    pad_pd,
    input  logic             pad_last,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [DW-1:0]    out_pd,
    output logic             out_src,
    output logic             out_last,
    output logic [CNT_W-1:0] dat_beat_cnt,
    output logic [CNT_W-1:0] pad_beat_cnt,
    output logic             arb_busy
);

    arb_state_e       state_reg;
    arb_state_e       state_next;
    logic             rr_last_reg;
    logic             gnt_dat;
    logic             gnt_pad;
    logic             acc;
    logic             dat_acc;
    logic             pad_acc;
    logic             beat_vld;
    logic             beat_src;
    logic             beat_last;
    logic [DW-1:0]    beat_pd;
    logic [1:0]       src_acc;

    // Grant decode: new bursts only from IDLE with arb_en, locked source otherwise.
    always_comb begin
        gnt_dat = 1'b0;
        gnt_pad = 1'b0;
        case (state_reg)
            IDLE: begin
                if (arb_en) begin
                    if (dat_vld && pad_vld) begin
                        if (rr_pick(rr_last_reg) == SRC_DAT) gnt_dat = 1'b1;
                        else                                 gnt_pad = 1'b1;
                    end else begin
                        gnt_dat = dat_vld;
                        gnt_pad = pad_vld;
                    end
                end
            end
            LOCK_DAT: gnt_dat = 1'b1;
            LOCK_PAD: gnt_pad = 1'b1;
            default:  ;
        endcase
    end

    // Ready is withheld while reset is asserted so no beat slips through.
    assign dat_rdy  = nvdla_core_rstn & acc & gnt_dat;
    assign pad_rdy  = nvdla_core_rstn & acc & gnt_pad;
    assign dat_acc  = dat_vld & dat_rdy;
    assign pad_acc  = pad_vld & pad_rdy;
    assign src_acc  = {pad_acc, dat_acc};

    assign beat_vld  = dat_acc | pad_acc;
    assign beat_src  = pad_acc ? SRC_PAD : SRC_DAT;
    assign beat_last = pad_acc ? pad_last : dat_last;
    assign beat_pd   = pad_acc ? pad_pd : dat_pd;

    // Next state: only an accepted beat moves the FSM.
    always_comb begin
        state_next = state_reg;
        if (beat_vld) begin
            if (beat_last)              state_next = IDLE;
            else if (beat_src == SRC_PAD) state_next = LOCK_PAD;
            else                        state_next = LOCK_DAT;
        end
    end

    // State register.
    always_ff @(posedge nvdla_op_gated_clk_fp16 or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) state_reg <= IDLE;
        else                  state_reg <= state_next;
    end

    // Round-robin pointer remembers who completed the last burst.
    always_ff @(posedge nvdla_op_gated_clk_fp16 or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn)          rr_last_reg <= SRC_PAD;
        else if (beat_vld && beat_last) rr_last_reg <= beat_src;
    end

    // Per-source accepted-beat counters, free-running with wrap.
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;
        always_ff @(posedge nvdla_op_gated_clk_fp16 or negedge nvdla_core_rstn) begin
            if (!nvdla_core_rstn)  cnt_reg <= '0;
            else if (src_acc[gi])  cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign dat_beat_cnt = g_cnt[0].cnt_reg;
    assign pad_beat_cnt = g_cnt[1].cnt_reg;

    nv_nvdla_pdp_cal2d_pipe_stage #(
        .W     (DW + 2),
        .RST_W (2)
    ) u_stage (
        .nvdla_op_gated_clk_fp16 (nvdla_op_gated_clk_fp16),
        .nvdla_core_rstn         (nvdla_core_rstn),
        .vld_in                  (beat_vld),
        .rdy_in                  (acc),
        .data_in                 ({beat_src, beat_last, beat_pd}),
        .vld_out                 (out_vld),
        .rdy_out                 (out_rdy),
        .data_out                ({out_src, out_last, out_pd})
    );

    assign arb_busy = (state_reg != IDLE) | out_vld;

endmodule

// File: tb/tb_nv_nvdla_pdp_cal2d_pad_line_arb.sv
// Scoreboard bench for the PDP cal2d pad-line arbiter.
module tb_nv_nvdla_pdp_cal2d_pad_line_arb;
    import nv_nvdla_pdp_cal2d_arb_pkg::*;

    localparam int DW    = 115;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             nvdla_core_rstn;
    logic             arb_en;
    logic             dat_vld, dat_rdy, dat_last;
    logic [DW-1:0]    dat_pd;
    logic             pad_vld, pad_rdy, pad_last;
    logic [DW-1:0]    pad_pd;
    logic             out_vld, out_rdy, out_src, out_last;
    logic [DW-1:0]    out_pd;
    logic [CNT_W-1:0] dat_beat_cnt, pad_beat_cnt;
    logic             arb_busy;

    typedef logic [DW:0]   src_beat_t;   // {last, pd}
    typedef logic [DW+1:0] out_beat_t;   // {src, last, pd}

    src_beat_t dat_q[$];
    src_beat_t pad_q[$];
    out_beat_t exp_q[$];

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    nv_nvdla_pdp_cal2d_pad_line_arb #(.DW(DW), .CNT_W(CNT_W)) dut (
        .nvdla_op_gated_clk_fp16 (clk),
        .nvdla_core_rstn         (nvdla_core_rstn),
        .arb_en                  (arb_en),
        .dat_vld                 (dat_vld),
        .dat_rdy                 (dat_rdy),
        .dat_pd                  (dat_pd),
        .dat_last                (dat_last),
        .pad_vld                 (pad_vld),
        .pad_rdy                 (pad_rdy),
        .pad_pd                  (pad_pd),
        .pad_last                (pad_last),
        .out_vld                 (out_vld),
        .out_rdy                 (out_rdy),
        .out_pd                  (out_pd),
        .out_src                 (out_src),
        .out_last                (out_last),
        .dat_beat_cnt            (dat_beat_cnt),
        .pad_beat_cnt            (pad_beat_cnt),
        .arb_busy                (arb_busy)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic send(input logic src, input logic [DW-1:0] pd, input logic last, input bit with_exp);
        if (src == SRC_DAT) dat_q.push_back({last, pd});
        else                pad_q.push_back({last, pd});
        if (with_exp) exp_q.push_back({src, last, pd});
    endtask

    task automatic wait_fire(input logic src, input int budget);
        int  n;
        logic f;
        n = 0;
        f = 1'b0;
        while (!f && n < budget) begin
            @(negedge clk);
            f = (src == SRC_PAD) ? (pad_vld & pad_rdy) : (dat_vld & dat_rdy);
            n++;
        end
        if (!f) begin
            n_total++;
            $display("FAIL wait_fire: no handshake within %0d cycles, required one", budget);
        end
    endtask

    task automatic wait_out_vld(input int budget);
        int n;
        n = 0;
        while (!out_vld && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!out_vld) begin
            n_total++;
            $display("FAIL wait_out_vld: out_vld=0 after %0d cycles, required 1", budget);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_vld) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || out_vld) begin
            n_total++;
            $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1;
        nvdla_core_rstn = 1'b0;
        @(posedge clk); #1;
        nvdla_core_rstn = 1'b1;
    endtask

    // Source drivers: a beat leaves its queue once a handshake is seen.
    initial begin : drv
        logic dfire, pfire;
        src_beat_t tmp;
        dat_vld = 1'b0; dat_pd = '0; dat_last = 1'b0;
        pad_vld = 1'b0; pad_pd = '0; pad_last = 1'b0;
        forever begin
            @(negedge clk);
            dfire = dat_vld & dat_rdy;
            pfire = pad_vld & pad_rdy;
            @(posedge clk); #1;
            if (dfire && dat_q.size() > 0) tmp = dat_q.pop_front();
            if (pfire && pad_q.size() > 0) tmp = pad_q.pop_front();
            if (dat_q.size() > 0) begin
                dat_vld = 1'b1; {dat_last, dat_pd} = dat_q[0];
            end else begin
                dat_vld = 1'b0;
            end
            if (pad_q.size() > 0) begin
                pad_vld = 1'b1; {pad_last, pad_pd} = pad_q[0];
            end else begin
                pad_vld = 1'b0;
            end
        end
    end

    // Monitor: every output transfer is matched against the scoreboard.
    initial begin : mon
        out_beat_t e;
        forever begin
            @(negedge clk);
            if (nvdla_core_rstn === 1'b1 && out_vld && out_rdy) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_beat: got src=%0d pd=%0h, required no beat", out_src, out_pd);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_beat", {out_src, out_last, out_pd}, e);
                end
            end
        end
    end

    initial begin : main
        nvdla_core_rstn = 1'b0;
        arb_en          = 1'b1;
        out_rdy         = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_vld", out_vld, 0);
        chk("rst_out_src_last", {out_src, out_last}, 0);
        chk("rst_cnts", {dat_beat_cnt, pad_beat_cnt}, 0);
        chk("rst_busy", arb_busy, 0);
        @(posedge clk); #1;
        nvdla_core_rstn = 1'b1;

        // 1: three-beat dat burst, one-cycle latency
        for (int i = 0; i < 3; i++) send(SRC_DAT, DW'(32'h101 + i), i == 2, 1'b1);
        wait_fire(SRC_DAT, 20);
        @(negedge clk);
        chk("t1_latency", {out_vld, out_pd}, {1'b1, 115'h101});
        wait_drain(50);
        chk("t1_dat_cnt", dat_beat_cnt, 3);
        chk("t1_idle", arb_busy, 0);

        // 2: both valid, single-beat bursts alternate starting with dat
        reset_pulse();
        for (int i = 0; i < 4; i++) begin
            send(SRC_DAT, DW'(32'h201 + i), 1'b1, 1'b1);
            send(SRC_PAD, DW'(32'h2a1 + i), 1'b1, 1'b1);
        end
        wait_drain(50);
        chk("t2_cnts", {dat_beat_cnt, pad_beat_cnt}, {16'd4, 16'd4});

        // 3: pad arrives mid dat burst and waits for the lock to release
        for (int i = 0; i < 4; i++) send(SRC_DAT, DW'(32'h301 + i), i == 3, 1'b1);
        wait_fire(SRC_DAT, 20);
        send(SRC_PAD, DW'(32'h3f1), 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_pad_blocked", {pad_vld, pad_rdy}, 2'b10);
        end
        @(negedge clk);
        chk("t3_pad_granted", {pad_vld, pad_rdy}, 2'b11);
        wait_drain(50);

        // 4: downstream stall holds the output and blocks both sources
        @(posedge clk); #1;
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) send(SRC_DAT, DW'(32'h401 + i), i == 2, 1'b1);
        wait_out_vld(20);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_stall_pd", {out_vld, out_pd}, {1'b1, 115'h401});
            chk("t4_stall_rdy", {dat_rdy, pad_rdy}, 2'b00);
        end
        @(posedge clk); #1;
        out_rdy = 1'b1;
        wait_drain(50);
        chk("t4_cnts", {dat_beat_cnt, pad_beat_cnt}, {16'd11, 16'd5});

        // 5: arb_en drops mid burst; burst completes, nothing new granted
        for (int i = 0; i < 4; i++) send(SRC_DAT, DW'(32'h501 + i), i == 3, 1'b1);
        wait_fire(SRC_DAT, 20);
        @(posedge clk); #1;
        arb_en = 1'b0;
        send(SRC_PAD, DW'(32'h5f1), 1'b1, 1'b0);
        wait_drain(50);
        @(negedge clk);
        chk("t5_no_grant", {pad_vld, pad_rdy}, 2'b10);
        chk("t5_busy_low", arb_busy, 0);
        exp_q.push_back({SRC_PAD, 1'b1, DW'(32'h5f1)});
        @(posedge clk); #1;
        arb_en = 1'b1;
        wait_drain(50);

        // 6: async reset mid burst, then dat wins, then pad counter wraps
        @(posedge clk); #1;
        out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) send(SRC_DAT, DW'(32'h601 + i), i == 3, 1'b0);
        wait_out_vld(20);
        #1;
        nvdla_core_rstn = 1'b0;
        #1;
        chk("t6_async_vld", out_vld, 0);
        chk("t6_rst_rdy", {dat_vld, dat_rdy}, 2'b10);
        dat_q.delete();
        repeat (2) @(posedge clk);
        #1;
        nvdla_core_rstn = 1'b1;
        out_rdy = 1'b1;
        @(negedge clk);
        chk("t6_cnts_zero", {dat_beat_cnt, pad_beat_cnt}, 0);
        send(SRC_DAT, DW'(32'h6a1), 1'b1, 1'b1);
        send(SRC_PAD, DW'(32'h6b1), 1'b1, 1'b1);
        wait_drain(50);
        for (int i = 0; i < 65536; i++) send(SRC_PAD, DW'(i), 1'b1, 1'b1);
        wait_drain(70000);
        chk("t6_wrap_cnts", {dat_beat_cnt, pad_beat_cnt}, {16'd1, 16'd1});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
